// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants, state encoding and round/saturate helper for the DCT coefficient accumulator
package dct_pkg;

  localparam int DCT_N       = 8;
  localparam int DCT_SAMPLES = DCT_N * DCT_N;
  localparam int Q_FRAC      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dct_state_e;

  // Round half up by 'shift' bits, then clamp into a signed 'out_w'-bit range.
  // Worked at 64 bits so the rounding add can never wrap the accumulator value.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 out_w
  );
    logic signed [63:0] rnd;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    r   = (acc + rnd) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_coeff_accumulator_mac.sv
// rtl/dct_coeff_accumulator_mac.sv - registered pixel*cos multiply-accumulate with clear and round/saturate finaliser
module dct_mac_sat
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 1,
  parameter int COS_W       = 32,
  parameter int ACC_W       = 32,
  parameter int OUT_SHIFT   = 8,
  parameter int COEFF_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      acc_en_i,
  input  logic                      finalize_i,
  input  logic [PIX_W-1:0]          pix_i,
  input  logic signed [COS_W-1:0]   cos_i,
  output logic signed [COEFF_W-1:0] coeff_o
);

  localparam int OP_W   = PIX_W + 1;
  localparam int PROD_W = OP_W + COS_W;

  logic signed [COS_W-1:0]   cos_q;
  logic signed [OP_W-1:0]    op;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [COEFF_W-1:0] coeff_q;
  logic signed [63:0]        fin_wide;

  // Pixel operand: optionally re-centred around zero (JPEG level shift).
  always_comb begin
    op = signed'({1'b0, pix_i});
    if (LEVEL_SHIFT != 0) begin
      op = signed'({1'b0, pix_i}) - signed'(OP_W'(2 ** (PIX_W - 1)));
    end
  end

  assign prod     = PROD_W'(op) * PROD_W'(cos_q);
  assign prod_ext = ACC_W'(prod);

  // Next accumulator value; clear wins so a new run never inherits a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // The finaliser sees the sum including the product landing this same cycle.
  assign fin_wide = sat_round(64'(acc_d), OUT_SHIFT, COEFF_W);

  // Cos term is captured while its index is on the LUT, so it lines up with the RAM data next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cos_q   <= '0;
      acc_q   <= '0;
      coeff_q <= '0;
    end else begin
      cos_q <= cos_i;
      acc_q <= acc_d;
      if (finalize_i) begin
        coeff_q <= COEFF_W'(fin_wide);
      end
    end
  end

  assign coeff_o = coeff_q;

endmodule

// File: rtl/dct_coeff_accumulator.sv
// rtl/dct_coeff_accumulator.sv - sequences the 64 block positions and produces one DCT coefficient per run
module dct_coeff_accumulator
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 1,
  parameter int COS_W       = 32,
  parameter int ACC_W       = 32,
  parameter int OUT_SHIFT   = 8,
  parameter int COEFF_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic [2:0]                n1,
  output logic [2:0]                n2,
  input  logic signed [COS_W-1:0]   cos_term,
  output logic [5:0]                pix_addr,
  input  logic [PIX_W-1:0]          pix_rdata,
  output logic signed [COEFF_W-1:0] coeff,
  output logic                      done
);

  dct_state_e state_q;
  logic [5:0] idx_q;
  logic       busy_q;
  logic       done_q;
  logic       valid_q;

  logic       clear;
  logic       finalize;

  // Sequencer: IDLE -> ISSUE (64 addresses) -> DRAIN (last accumulate) -> DONE (pulse) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= (state_q == ISSUE);
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (idx_q == 6'(DCT_SAMPLES - 1)) begin
            state_q <= DRAIN;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clear    = (state_q == IDLE) && start;
  assign finalize = (state_q == DRAIN);

  dct_mac_sat #(
    .PIX_W      (PIX_W),
    .LEVEL_SHIFT(LEVEL_SHIFT),
    .COS_W      (COS_W),
    .ACC_W      (ACC_W),
    .OUT_SHIFT  (OUT_SHIFT),
    .COEFF_W    (COEFF_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .acc_en_i  (valid_q),
    .finalize_i(finalize),
    .pix_i     (pix_rdata),
    .cos_i     (cos_term),
    .coeff_o   (coeff)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_addr = idx_q;
  assign n1       = idx_q[5:3];
  assign n2       = idx_q[2:0];

endmodule

// File: tb/tb_dct_coeff_accumulator.sv
// tb/tb_dct_coeff_accumulator.sv - directed self-checking bench for dct_coeff_accumulator
module tb_dct_coeff_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy;
  logic [2:0]         n1;
  logic [2:0]         n2;
  logic signed [31:0] cos_term;
  logic [5:0]         pix_addr;
  logic [7:0]         pix_rdata;
  logic signed [15:0] coeff;
  logic               done;

  logic [7:0] pix_mem [64];
  int         cos_const;
  bit         use_lut;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  dct_coeff_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .n1       (n1),
    .n2       (n2),
    .cos_term (cos_term),
    .pix_addr (pix_addr),
    .pix_rdata(pix_rdata),
    .coeff    (coeff),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pix_rdata <= pix_mem[pix_addr];

  always_comb begin
    cos_term = 32'(cos_const);
    if (use_lut) begin
      if ({n1, n2} == 6'd27) cos_term = 32'sd139;
      else if (n2[0])        cos_term = -32'sd200;
      else                   cos_term = 32'sd200;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic fill_pix(input int val);
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'(val);
  endtask

  task automatic run_block(input string tag, input int exp_coeff, input bit mid_starts,
                           input bit restart, input int rst_at);
    int done_cnt    = 0;
    int first_done  = -1;
    int second_done = -1;
    int coeff1      = 0;
    int coeff2      = 0;
    int busy_err    = 0;
    int addr_err    = 0;
    int last        = restart ? 140 : 70;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = c; coeff1 = int'(coeff);
        end else if (second_done < 0) begin
          second_done = c; coeff2 = int'(coeff);
        end
      end
      if (rst_at == 0 && c <= 67 && busy !== (c <= 66)) busy_err++;
      if (rst_at == 0 && c <= 64 && (pix_addr !== 6'(c - 1) || {n1, n2} !== pix_addr)) addr_err++;
      if (rst_at != 0 && c == rst_at + 1) begin
        check_eq({tag, "_rst_busy"}, int'(busy), 0);
        check_eq({tag, "_rst_coeff"}, int'(coeff), 0);
      end
      start = (mid_starts && (c == 10 || c == 40)) || (restart && c == 67);
      reset = (rst_at != 0 && c == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
    if (rst_at != 0) begin
      check_eq({tag, "_no_done"}, done_cnt, 0);
    end else begin
      check_eq({tag, "_done_cycle"}, first_done, 66);
      check_eq({tag, "_coeff"}, coeff1, exp_coeff);
      check_eq({tag, "_busy_window"}, busy_err, 0);
      check_eq({tag, "_addr_seq"}, addr_err, 0);
      if (restart) begin
        check_eq({tag, "_done_cnt"}, done_cnt, 2);
        check_eq({tag, "_done2_cycle"}, second_done, 133);
        check_eq({tag, "_coeff2"}, coeff2, exp_coeff);
      end else begin
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_coeff_hold"}, int'(coeff), exp_coeff);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cos_const = 256;
    use_lut   = 1'b0;
    fill_pix(255);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_coeff", int'(coeff), 0);
    check_eq("rst_addr", int'(pix_addr), 0);
    check_eq("rst_n1n2", int'({n1, n2}), 0);
    reset = 1'b0;
    @(negedge clk);

    // 127*256*64 = 2080768 -> 8128
    run_block("unity", 8128, 1'b0, 1'b0, 0);

    // 127*246*64 = 1999488 -> 7810.5 rounds up
    cos_const = 246;
    run_block("half_up", 7811, 1'b0, 1'b0, 0);

    // only addr 27 is non-zero after level shift: 100*139 = 13900 -> 54
    use_lut = 1'b1;
    fill_pix(128);
    pix_mem[27] = 8'd228;
    run_block("lut_spike", 54, 1'b0, 1'b0, 0);
    fill_pix(128);
    run_block("lut_flat", 0, 1'b0, 1'b0, 0);

    use_lut = 1'b0;
    fill_pix(255);
    cos_const = 32767;
    run_block("sat_pos", 32767, 1'b0, 1'b0, 0);
    cos_const = -32767;
    run_block("sat_neg", -32768, 1'b0, 1'b0, 0);

    cos_const = 256;
    run_block("ign_start", 8128, 1'b1, 1'b1, 0);

    cos_const = 246;
    run_block("abort", 0, 1'b0, 1'b0, 30);
    run_block("after_abort", 7811, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
